// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, FSM state type and piano key lookup for the
// PS/2 key event controller.
//   - PS2_* byte constants: prefixes, ignored keyboard replies, overrun codes
//   - ps2_state_e: prefix-tracking FSM states
//   - note_hit_t / key_to_note(): maps a non-extended scan code to {hit, idx}
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_OVR_LO = 8'h00;
    localparam logic [7:0] PS2_OVR_HI = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } ps2_state_e;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } note_hit_t;

    // Scan codes of the eight piano keys, lowest note first.
    function automatic note_hit_t key_to_note(input logic [7:0] code);
        note_hit_t r;
        r.hit = 1'b1;
        r.idx = 3'd0;
        case (code)
            8'h1C:   r.idx = 3'd0;
            8'h1B:   r.idx = 3'd1;
            8'h23:   r.idx = 3'd2;
            8'h2B:   r.idx = 3'd3;
            8'h34:   r.idx = 3'd4;
            8'h33:   r.idx = 3'd5;
            8'h3B:   r.idx = 3'd6;
            8'h42:   r.idx = 3'd7;
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_note_tracker.sv
// ps2_note_tracker: held-key bitmap and active-note selection.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_make/i_break : one-cycle key event strobes (mutually exclusive)
//   i_hit, i_idx   : event refers to piano key i_idx (non-extended, mapped)
//   i_clr          : drop every held key (receiver overrun)
//   o_held         : key i_idx is currently held (typematic repeat detect)
//   o_note_mask    : bit n set = piano key n held
//   o_note_active  : at least one key held
//   o_note_idx     : most recently pressed held key
module ps2_note_tracker
    import ps2_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_make,
    input  logic       i_break,
    input  logic       i_hit,
    input  logic [2:0] i_idx,
    input  logic       i_clr,
    output logic       o_held,
    output logic [7:0] o_note_mask,
    output logic       o_note_active,
    output logic [2:0] o_note_idx
);

    logic [7:0] r_mask;
    logic [2:0] r_idx;
    logic [7:0] w_mask_next;
    logic [2:0] w_idx_next;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_mask_next = r_mask;
        w_idx_next  = r_idx;
        if (i_clr) begin
            w_mask_next = '0;
        end else if (i_make && i_hit && !r_mask[i_idx]) begin
            w_mask_next[i_idx] = 1'b1;
            w_idx_next         = i_idx;
        end else if (i_break && i_hit) begin
            w_mask_next[i_idx] = 1'b0;
            // Releasing the sounding note hands over to the highest key still held;
            // with nothing left held the last index is kept.
            if (r_mask[i_idx] && (r_idx == i_idx) && (|w_mask_next)) begin
                for (int i = 0; i < 8; i++) begin
                    if (w_mask_next[i]) w_idx_next = 3'(i);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
        if (!i_rst_n) begin
            r_mask <= '0;
            r_idx  <= '0;
        end else begin
            r_mask <= w_mask_next;
            r_idx  <= w_idx_next;
        end
    end

    assign o_held        = r_mask[i_idx];
    assign o_note_mask   = r_mask;
    assign o_note_active = |r_mask;
    assign o_note_idx    = r_idx;

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl: turns raw PS/2 scan-code bytes into make/break events
// and drives the held-note state for the tone generator.
//   i_clk, i_rst_n          : clock, synchronous active-low reset
//   i_rx_byte, i_rx_valid   : received byte and its one-cycle strobe
//   o_key_code, o_key_ext   : code / E0 flag of the last completed event
//   o_key_make, o_key_break : one-cycle event pulses
//   o_note_mask/active/idx  : held piano keys and selected note
//   o_err                   : one-cycle pulse on overrun code or prefix timeout
module ps2_key_event_ctrl
    import ps2_pkg::*;
#(
    parameter int    TIMEOUT_CYCLES = 100000,
    localparam int   CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_rx_byte,
    input  logic       i_rx_valid,
    output logic [7:0] o_key_code,
    output logic       o_key_ext,
    output logic       o_key_make,
    output logic       o_key_break,
    output logic [7:0] o_note_mask,
    output logic       o_note_active,
    output logic [2:0] o_note_idx,
    output logic       o_err
);

    ps2_state_e       r_state;
    ps2_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic       w_evt;
    logic       w_evt_brk;
    logic       w_evt_ext;
    logic       w_ovr;
    logic       w_timeout;
    logic       w_hit;
    logic       w_held;
    note_hit_t  w_note;

    logic [7:0] r_key_code;
    logic       r_key_ext;
    logic       r_key_make;
    logic       r_key_break;
    logic       r_err;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_evt        = 1'b0;
        w_evt_brk    = 1'b0;
        w_evt_ext    = 1'b0;
        w_ovr        = 1'b0;
        w_timeout    = 1'b0;
        if (i_rx_valid) begin
            w_cnt_next = '0;
            if (i_rx_byte == PS2_OVR_LO || i_rx_byte == PS2_OVR_HI) begin
                w_ovr        = 1'b1;
                w_state_next = ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_rx_byte == PS2_EXT) begin
                            w_state_next = ST_EXT;
                        end else if (i_rx_byte == PS2_BRK) begin
                            w_state_next = ST_BRK;
                        end else if (i_rx_byte != PS2_ACK && i_rx_byte != PS2_BAT &&
                                     i_rx_byte != PS2_RESEND) begin
                            w_evt = 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (i_rx_byte == PS2_BRK) begin
                            w_state_next = ST_EXT_BRK;
                        end else if (i_rx_byte != PS2_EXT) begin
                            w_evt        = 1'b1;
                            w_evt_ext    = 1'b1;
                            w_state_next = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        if (i_rx_byte == PS2_EXT) begin
                            w_state_next = ST_EXT;
                        end else if (i_rx_byte != PS2_BRK) begin
                            w_evt        = 1'b1;
                            w_evt_brk    = 1'b1;
                            w_state_next = ST_IDLE;
                        end
                    end
                    ST_EXT_BRK: begin
                        if (i_rx_byte == PS2_EXT) begin
                            w_state_next = ST_EXT;
                        end else if (i_rx_byte != PS2_BRK) begin
                            w_evt        = 1'b1;
                            w_evt_brk    = 1'b1;
                            w_evt_ext    = 1'b1;
                            w_state_next = ST_IDLE;
                        end
                    end
                    default: w_state_next = ST_IDLE;
                endcase
            end
        end else if (r_state != ST_IDLE) begin
            // The counter is 0 in the cycle after a prefix byte, so it reads
            // TIMEOUT_CYCLES-1 exactly TIMEOUT_CYCLES cycles after that byte.
            // A byte arriving in that same cycle takes the branch above instead.
            if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                w_timeout    = 1'b1;
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end else begin
                w_cnt_next = r_cnt + CNT_W'(1);
            end
        end
    end

    // Extended codes are never piano keys.
    assign w_note = key_to_note(i_rx_byte);
    assign w_hit  = w_note.hit && !w_evt_ext;

    ps2_note_tracker u_tracker (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_make        (w_evt && !w_evt_brk),
        .i_break       (w_evt && w_evt_brk),
        .i_hit         (w_hit),
        .i_idx         (w_note.idx),
        .i_clr         (w_ovr),
        .o_held        (w_held),
        .o_note_mask   (o_note_mask),
        .o_note_active (o_note_active),
        .o_note_idx    (o_note_idx)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_key_code  <= '0;
            r_key_ext   <= 1'b0;
            r_key_make  <= 1'b0;
            r_key_break <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            // A typematic repeat of a held piano key still updates key_code
            // but does not retrigger the note.
            r_key_make  <= w_evt && !w_evt_brk && !(w_hit && w_held);
            r_key_break <= w_evt && w_evt_brk;
            r_err       <= w_ovr || w_timeout;
            if (w_evt) begin
                r_key_code <= i_rx_byte;
                r_key_ext  <= w_evt_ext;
            end
        end
    end

    assign o_key_code  = r_key_code;
    assign o_key_ext   = r_key_ext;
    assign o_key_make  = r_key_make;
    assign o_key_break = r_key_break;
    assign o_err       = r_err;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// tb_ps2_key_event_ctrl: directed + randomized bench for ps2_key_event_ctrl,
// every cycle compared against a behavioural model of the byte protocol.
module tb_ps2_key_event_ctrl;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_make;
    logic       key_break;
    logic [7:0] note_mask;
    logic       note_active;
    logic [2:0] note_idx;
    logic       err;

    int n_vec = 0;
    int n_err = 0;

    ps2_key_event_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_rx_byte     (rx_byte),
        .i_rx_valid    (rx_valid),
        .o_key_code    (key_code),
        .o_key_ext     (key_ext),
        .o_key_make    (key_make),
        .o_key_break   (key_break),
        .o_note_mask   (note_mask),
        .o_note_active (note_active),
        .o_note_idx    (note_idx),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] keymap [8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};
    logic [7:0] unmapped [4] = '{8'h75, 8'h1D, 8'h20, 8'h6B};

    bit         m_pfx, m_ext, m_brk;   // inside a prefix sequence, flags seen
    int         m_wait;                // cycles since the last prefix byte
    bit         held [8];
    logic [7:0] e_code;
    bit         e_ext, e_make, e_brk, e_err;
    int         e_idx;

    function automatic int piano_key(input logic [7:0] b);
        for (int k = 0; k < 8; k++) if (keymap[k] == b) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_pfx = 0; m_ext = 0; m_brk = 0; m_wait = 0;
        foreach (held[k]) held[k] = 0;
        e_code = 8'h00; e_ext = 0; e_make = 0; e_brk = 0; e_err = 0; e_idx = 0;
    endtask

    task automatic model_event(input logic [7:0] b, input bit ext, input bit brk);
        int  k;
        bit  any;
        k = ext ? -1 : piano_key(b);
        e_code = b;
        e_ext  = ext;
        if (!brk) begin
            if (k < 0) e_make = 1;
            else if (!held[k]) begin
                held[k] = 1; e_idx = k; e_make = 1;
            end
        end else begin
            e_brk = 1;
            if (k >= 0 && held[k]) begin
                held[k] = 0;
                any = 0;
                foreach (held[j]) any |= held[j];
                if (e_idx == k && any)
                    for (int j = 7; j >= 0; j--) if (held[j]) begin e_idx = j; break; end
            end
        end
    endtask

    task automatic model_step(input bit v, input logic [7:0] b);
        e_make = 0; e_brk = 0; e_err = 0;
        if (v) begin
            m_wait = 0;
            if (b == 8'h00 || b == 8'hFF) begin
                m_pfx = 0; m_ext = 0; m_brk = 0;
                foreach (held[k]) held[k] = 0;
                e_err = 1;
            end else if (b == 8'hE0) begin
                m_pfx = 1; m_ext = 1; m_brk = 0;
            end else if (b == 8'hF0) begin
                m_pfx = 1; m_brk = 1;
            end else if (!m_pfx && (b == 8'hFA || b == 8'hAA || b == 8'hFE)) begin
                // keyboard reply outside a sequence: dropped
            end else begin
                model_event(b, m_ext, m_brk);
                m_pfx = 0; m_ext = 0; m_brk = 0;
            end
        end else if (m_pfx) begin
            m_wait++;
            if (m_wait == T) begin
                e_err = 1;
                m_pfx = 0; m_ext = 0; m_brk = 0;
            end
        end
    endtask

    function automatic logic [31:0] exp_vec();
        logic [7:0] m;
        for (int k = 0; k < 8; k++) m[k] = held[k];
        return {8'h00, e_code, e_ext, e_make, e_brk, m, |m, 3'(e_idx), e_err};
    endfunction

    function automatic logic [31:0] obs_vec();
        return {8'h00, key_code, key_ext, key_make, key_break,
                note_mask, note_active, note_idx, err};
    endfunction

    // ---------------- checking and stimulus helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag, input bit v, input logic [7:0] b);
        rx_valid = v;
        rx_byte  = b;
        model_step(v, b);
        @(posedge clk);
        @(negedge clk);
        check(tag, obs_vec(), exp_vec());
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("reset_outputs", obs_vec(), 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic send(input string tag, input logic [7:0] b);
        tick(tag, 1'b1, b);
    endtask

    initial begin
        int r;
        int gap;
        logic [7:0] b;

        do_reset();

        // make then break of piano key 0
        send("a_make", 8'h1C);
        check("a_make_fields", {key_make, key_break, key_code, note_mask, note_idx},
              {1'b1, 1'b0, 8'h1C, 8'h01, 3'd0});
        send("a_f0", 8'hF0);
        send("a_brk", 8'h1C);
        check("a_brk_fields", {key_make, key_break, key_code, note_mask, note_active},
              {1'b0, 1'b1, 8'h1C, 8'h00, 1'b0});

        // extended make / break leave the mask alone
        send("b_e0", 8'hE0);
        send("b_emake", 8'h75);
        check("b_emake_fields", {key_make, key_ext, key_code}, {1'b1, 1'b1, 8'h75});
        send("b_e0b", 8'hE0);
        send("b_f0", 8'hF0);
        send("b_ebrk", 8'h75);
        check("b_ebrk_fields", {key_break, key_ext, key_code, note_mask},
              {1'b1, 1'b1, 8'h75, 8'h00});

        // priority: most recent wins, release falls back to highest held
        send("c_23", 8'h23);
        check("c_mask04", {note_mask, note_idx}, {8'h04, 3'd2});
        send("c_42", 8'h42);
        check("c_mask84", {note_mask, note_idx}, {8'h84, 3'd7});
        send("c_f0", 8'hF0);
        send("c_brk42", 8'h42);
        check("c_back04", {note_mask, note_idx}, {8'h04, 3'd2});
        send("c_f0b", 8'hF0);
        send("c_brk23", 8'h23);

        // typematic repeat pulses make once
        send("d_rep1", 8'h1C);
        check("d_first", {key_make, note_mask}, {1'b1, 8'h01});
        send("d_rep2", 8'h1C);
        check("d_second", {key_make, note_mask}, {1'b0, 8'h01});
        send("d_rep3", 8'h1C);
        check("d_third", {key_make, note_mask}, {1'b0, 8'h01});
        send("d_f0", 8'hF0);
        send("d_rel", 8'h1C);

        // timeout after a lone F0, then the next code is a make
        send("e_f0", 8'hF0);
        for (int i = 1; i <= 20; i++) begin
            tick("e_idle", 1'b0, 8'h1C);
            if (i == T - 1) check("e_no_err_early", {31'd0, err}, 32'd0);
            if (i == T)     check("e_timeout_err", {31'd0, err}, 32'd1);
        end
        send("e_make", 8'h1C);
        check("e_make_fields", {key_make, key_break, note_mask, err}, {1'b1, 1'b0, 8'h01, 1'b0});
        send("e_f0b", 8'hF0);
        send("e_rel", 8'h1C);

        // byte arriving in the timeout cycle wins
        send("f_f0", 8'hF0);
        for (int i = 1; i < T; i++) tick("f_idle", 1'b0, 8'h00);
        send("f_edge", 8'h1C);
        check("f_edge_fields", {key_make, key_break, err}, {1'b0, 1'b1, 1'b0});
        tick("f_after", 1'b0, 8'h00);
        check("f_after_no_err", {31'd0, err}, 32'd0);

        // overrun drops held keys
        send("g_1c", 8'h1C);
        send("g_23", 8'h23);
        check("g_held", {note_mask, note_idx}, {8'h05, 3'd2});
        send("g_ovr", 8'hFF);
        check("g_ovr_fields", {err, key_make, key_break, note_mask, note_active},
              {1'b1, 1'b0, 1'b0, 8'h00, 1'b0});

        // reset mid-sequence discards the prefix
        send("h_e0", 8'hE0);
        send("h_f0", 8'hF0);
        do_reset();
        send("h_1b", 8'h1B);
        check("h_make_fields", {key_make, key_ext, note_mask, note_idx},
              {1'b1, 1'b0, 8'h02, 3'd1});

        // randomized byte stream with gaps, some around the timeout boundary
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 15)      b = 8'hE0;
            else if (r < 30) b = 8'hF0;
            else if (r < 65) b = keymap[$urandom_range(0, 7)];
            else if (r < 80) b = unmapped[$urandom_range(0, 3)];
            else if (r < 90) begin
                r = $urandom_range(0, 2);
                b = (r == 0) ? 8'hFA : (r == 1) ? 8'hAA : 8'hFE;
            end
            else if (r < 93) b = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            else             b = 8'($urandom);
            send("rnd_byte", b);
            r = $urandom_range(0, 99);
            if (r < 70)      gap = 0;
            else if (r < 92) gap = $urandom_range(1, 3);
            else             gap = $urandom_range(T - 2, T + 2);
            for (int g = 0; g < gap; g++) tick("rnd_gap", 1'b0, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
- Sits between the PS/2 frame receiver and the tone generator in the e-piano.
- Sequences raw received scan-code bytes into clean make/break key events, tracking the E0 (extended) and F0 (break) prefixes.
- Tracks which of the 8 piano keys are held and selects one active note for the tone generator: the most recently pressed held key wins.
- Recovers from truncated prefix sequences and receiver overrun codes.

Parameters:
- TIMEOUT_CYCLES, 100000, clk cycles allowed between a prefix byte and its following byte before the sequence is abandoned (2 ms at 50 MHz).
- CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived; do not override).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- rx_byte  in  8  scan-code byte from the PS/2 receiver
- rx_valid  in  1  one-cycle strobe; rx_byte is valid this cycle
- key_code  out  8  scan code of the last completed event
- key_ext  out  1  last event carried the E0 prefix
- key_make  out  1  one-cycle pulse: make event
- key_break  out  1  one-cycle pulse: break event
- note_mask  out  8  bit n set = piano key n held
- note_active  out  1  at least one piano key held
- note_idx  out  3  selected note (valid when note_active)
- err  out  1  one-cycle pulse: overrun code or timeout

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - All outputs are 0.
  - FSM goes to IDLE and the timeout counter clears.
  - Reset mid-sequence discards the partial sequence.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions occur only on rx_valid.
  - IDLE:
    - E0 → EXT.
    - F0 → BRK.
    - FA, AA, FE → ignored; stay in IDLE.
    - Any other byte → make event, ext=0.
  - EXT:
    - F0 → EXT_BRK.
    - E0 → stay in EXT.
    - Other byte → make event, ext=1; → IDLE.
  - BRK:
    - E0 → EXT.
    - F0 → stay in BRK.
    - Other byte → break event, ext=0; → IDLE.
  - EXT_BRK:
    - E0 → EXT.
    - F0 → stay in EXT_BRK.
    - Other byte → break event, ext=1; → IDLE.
- Overrun bytes 00 and FF, in any state:
  - FSM → IDLE.
  - note_mask cleared.
  - err pulses.
  - No make/break pulse.
- Timeout:
  - Counter runs only in EXT, BRK and EXT_BRK.
  - Counter reloads to 0 on every rx_valid.
  - Reaching TIMEOUT_CYCLES → IDLE and err pulses; note_mask is unchanged.
  - If rx_valid arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the byte wins: it is processed and there is no err.
- Latency: key_code, key_ext and the pulse are registered and appear the cycle after the rx_valid of the final byte. note_mask, note_active and note_idx update in that same cycle.
- Piano key map (non-extended codes only):
  - 1C→0, 1B→1, 23→2, 2B→3, 34→4, 33→5, 3B→6, 42→7.
  - Extended codes never touch note_mask.
- Make of a mapped key:
  - Already held (typematic repeat): no key_make pulse; note state unchanged.
  - Not held: set its bit, note_idx = key, key_make pulses.
- Make of an unmapped key: key_make pulses every time, including repeats.
- Break of a mapped key:
  - Clear its bit; key_break pulses.
  - If it was note_idx and other keys remain held, note_idx = highest-index remaining held key.
  - Break of a key that is not held still pulses key_break; mask unchanged.
- note_active = |note_mask.
- note_idx keeps its last value when the mask becomes 0.
- key_make and key_break are never high in the same cycle.

Decomposition:
- Shared package ps2_pkg:
  - Prefix constants PS2_EXT=8'hE0, PS2_BRK=8'hF0.
  - Ignored codes PS2_ACK=8'hFA, PS2_BAT=8'hAA, PS2_RESEND=8'hFE.
  - Overrun codes 8'h00 and 8'hFF.
  - FSM state enum.
  - Function key_to_note(byte) returning {hit, idx[2:0]}.
- One sub-module, ps2_note_tracker: holds note_mask and note_idx; takes make/break plus index and implements hold/priority. The FSM and timeout stay in the top.

Test Plan (TIMEOUT_CYCLES=16):
- Bytes 1C, then F0 1C → make pulse key_code=1C, mask=01, note_idx=0; then break pulse, mask=00, note_active=0.
- E0 75 then E0 F0 75 → make with key_ext=1, then break with key_ext=1, key_code=75; mask stays 00.
- 23, 42, F0 42 → mask 04 → 84 (note_idx=7) → 04 (note_idx=2).
- 1C, 1C, 1C → exactly one key_make pulse; mask=01.
- F0 then 20 idle cycles then 1C → err pulse at cycle 16 after F0; 1C yields a make (not a break), mask=01. Variant: 1C arrives exactly at cycle 16 → break, no err.
- Hold 1C and 23, then byte FF → err pulse, mask=00, no make/break. Variant: rst_n low for one cycle mid E0 F0 → all outputs 0, next byte 1B → make, mask=02.
